ff_excitation_driver: RTL and testbench
=======================================

Name: ff_excitation_driver

Overview:
- Drives a target bit sequence into a downstream SR, JK, D or T flip-flop.
- For each requested next state, derives the excitation inputs from the flop type's excitation table (the inverse of the flop's characteristic table).
- Issues a clock-enable tick so the flop samples those inputs, then reads back the flop's q and flags any mismatch.
- Used as the stimulus/self-check source for the lab flip-flop blocks on board and in simulation.

Parameters:
- DIV_W, 23, tick divider width. tick pulses once every 2^DIV_W clk cycles. Simulation uses 2.
- CNT_W, 8, width of the error counter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- ff_type  in  2  flop type: 00=SR, 01=JK, 10=D, 11=T. Latched at request acceptance.
- req_valid  in  1  target-bit request valid
- req_bit  in  1  requested next q of the flop
- req_ready  out  1  high when a request can be accepted
- exc  out  2  excitation to the flop: SR={s,r}, JK={j,k}, D={d,0}, T={t,0}
- exc_valid  out  1  exc is being held for the flop
- tick  out  1  one-cycle clock enable for the downstream flop
- ff_q  in  1  q fed back from the downstream flop
- mismatch  out  1  one-cycle pulse: read-back q differs from target
- err_cnt  out  CNT_W  saturating count of mismatches
- busy  out  1  high when not in IDLE

Behaviour:
- Reset (rst=1 at a posedge) sets:
  - state=IDLE, cur=0, div=0, tick=0
  - exc=00, exc_valid=0, mismatch=0, err_cnt=0
  - latched type=00, latched target=0
- req_ready = (state==IDLE) && !rst, so it is 0 during reset.
- cur=0 after reset matches the flop's reset value q=0; the flop shares rst.
- Divider:
  - div runs freely, incrementing every cycle and wrapping at 2^DIV_W-1 -> 0.
  - tick is registered and is 1 for exactly the one cycle after div==2^DIV_W-1.
  - The divider is independent of the FSM; only rst clears it.
- IDLE:
  - req_ready=1, exc_valid=0, exc holds its last value.
  - On req_valid && req_ready: latch ff_type and req_bit (tgt), register exc from (type, cur, tgt), set exc_valid=1 on the next cycle, and go to DRIVE.
- Excitation tables, in order cur->tgt; don't-cares resolve to 0:
  - SR: 0->0 00, 0->1 10, 1->0 01, 1->1 00. SR=11 is never emitted.
  - JK: 0->0 00, 0->1 10, 1->0 01, 1->1 00.
  - D: {tgt,0}.
  - T: {cur^tgt,0}.
- DRIVE:
  - exc and exc_valid are held stable.
  - Wait for tick==1. The flop updates at the posedge ending that cycle.
  - Go to CHECK on the next cycle.
  - If tick is already 1 in the first DRIVE cycle, that tick is used.
- CHECK (exactly 1 cycle):
  - Sample ff_q.
  - If ff_q != tgt: mismatch=1 for this cycle, and err_cnt increments, saturating at all-ones.
  - cur <= ff_q, so the model resyncs to the real flop.
  - exc_valid <= 0 and return to IDLE.
- Back-to-back requests: a new request can be accepted the cycle after CHECK. At most one request is accepted per tick period.
- Latency from acceptance to CHECK ranges from 2 to 2^DIV_W+1 cycles, depending on tick phase.
- Changes to ff_type or req_bit outside acceptance have no effect on an in-flight request.
- req_valid while busy is ignored (req_ready=0). The requester must hold the request until accepted.
- rst mid-operation aborts immediately to the reset values. No mismatch is flagged for the aborted request.

Test Plan (DIV_W=2, tick every 4 cycles):
- Reset, then JK with targets 1,1,0,0 -> exc 10,00,01,00. ff_q follows 1,1,0,0. mismatch never pulses, err_cnt=0.
- SR with targets 1,0,1 from cur=0 -> exc 10,01,10, never 11. Each CHECK occurs exactly 1 cycle after its tick.
- T with targets 1,1,0 -> exc 10,00,10. D with targets 0,1 -> exc 00,10.
- Bench forces ff_q=0 while target=1 -> mismatch pulses for 1 cycle and err_cnt=1. Next request is computed from cur=0, e.g. JK target 1 gives exc 10.
- Hold req_valid=1 continuously -> req_ready is 0 during DRIVE/CHECK, only one request is accepted per tick period, and no request is dropped or duplicated.
- Assert rst during DRIVE -> next cycle state=IDLE, exc=00, exc_valid=0, err_cnt=0, tick=0. req_ready=1 the cycle after rst deasserts.
- With CNT_W=2, force 5 mismatches -> err_cnt saturates at 3.

Source files
------------

// File: rtl/ff_excitation_driver.sv
// Flip-flop excitation driver: turns target q bits into SR/JK/D/T inputs,
// ticks the downstream flop, and checks its read-back q.
module ff_excitation_driver #(
  parameter int DIV_W = 23,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       ff_type,
  input  logic             req_valid,
  input  logic             req_bit,
  output logic             req_ready,
  output logic [1:0]       exc,
  output logic             exc_valid,
  output logic             tick,
  input  logic             ff_q,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    CHECK
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [DIV_W-1:0] r_div;
  logic             r_tick;
  logic [1:0]       r_type;
  logic             r_tgt;
  logic             r_cur;
  logic [1:0]       r_exc;
  logic             r_exc_valid;
  logic [CNT_W-1:0] r_err;

  logic             w_accept;
  logic             w_mis;
  logic [1:0]       w_type;
  logic             w_tgt;
  logic [1:0]       w_exc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_div  <= r_div + DIV_W'(1);
      r_tick <= &r_div;
    end
  end

  assign req_ready = (r_state == IDLE) && !rst;
  assign w_accept  = req_valid && req_ready;
  assign w_mis     = (r_state == CHECK) && (ff_q != r_tgt);

  // Live inputs while idle, latched copies once a request is in flight
  assign w_type = (r_state == IDLE) ? ff_type : r_type;
  assign w_tgt  = (r_state == IDLE) ? req_bit : r_tgt;

  always_comb begin
    w_exc = 2'b00;
    unique case (w_type)
      2'b00,
      2'b01: w_exc = {~r_cur & w_tgt, r_cur & ~w_tgt};
      2'b10: w_exc = {w_tgt, 1'b0};
      2'b11: w_exc = {r_cur ^ w_tgt, 1'b0};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = DRIVE;
      DRIVE:   if (r_tick) w_next = CHECK;
      CHECK:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_type      <= 2'b00;
      r_tgt       <= 1'b0;
      r_cur       <= 1'b0;
      r_exc       <= 2'b00;
      r_exc_valid <= 1'b0;
      r_err       <= '0;
    end else begin
      if (w_accept) begin
        r_type      <= ff_type;
        r_tgt       <= req_bit;
        r_exc       <= w_exc;
        r_exc_valid <= 1'b1;
      end else if (r_state == DRIVE) begin
        r_exc <= w_exc;
      end
      if (r_state == CHECK) begin
        r_cur       <= ff_q;
        r_exc_valid <= 1'b0;
        if (w_mis && !(&r_err)) r_err <= r_err + CNT_W'(1);
      end
    end
  end

  assign exc       = r_exc;
  assign exc_valid = r_exc_valid;
  assign tick      = r_tick;
  assign mismatch  = w_mis;
  assign err_cnt   = r_err;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_ff_excitation_driver.sv
// Bench for ff_excitation_driver: behavioural downstream flop,
// vector table plus scoreboard of expected excitations.
module tb_ff_excitation_driver;

  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    ff_type = 2'b00;
  logic          req_valid = 1'b0;
  logic          req_bit = 1'b0;
  logic          req_ready;
  logic [1:0]    exc;
  logic          exc_valid;
  logic          tick;
  logic          ff_q;
  logic          mismatch;
  logic [CW-1:0] err_cnt;
  logic          busy;

  always #5 clk = ~clk;

  ff_excitation_driver #(.DIV_W(2), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .ff_type(ff_type),
    .req_valid(req_valid), .req_bit(req_bit),
    .req_ready(req_ready), .exc(exc),
    .exc_valid(exc_valid), .tick(tick),
    .ff_q(ff_q), .mismatch(mismatch),
    .err_cnt(err_cnt), .busy(busy)
  );

  // downstream flop; 'stuck' models a broken flop that ignores its enable
  logic       q_m = 1'b0;
  logic       stuck = 1'b0;
  logic [1:0] m_type = 2'b00;
  assign ff_q = q_m;

  always @(posedge clk) begin
    if (rst) q_m <= 1'b0;
    else if (tick && exc_valid && !stuck) begin
      case (m_type)
        2'd0: if (exc == 2'b10) q_m <= 1'b1;
              else if (exc == 2'b01) q_m <= 1'b0;
        2'd1: case (exc)
                2'b10: q_m <= 1'b1;
                2'b01: q_m <= 1'b0;
                2'b11: q_m <= ~q_m;
                default: ;
              endcase
        2'd2: q_m <= exc[1];
        default: if (exc[1]) q_m <= ~q_m;
      endcase
    end
  end

  int n_chk = 0;
  int n_err = 0;
  logic [1:0] sb[$];

  typedef struct {
    logic [1:0] t;
    logic       b;
    logic       stk;
    logic [1:0] x;
    logic       mis;
    int         err;
  } vec_t;

  vec_t tv[21];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s: timeout waiting for DUT", nm);
  endtask

  function automatic logic [1:0] exp_exc(input logic [1:0] t,
                                         input logic c, input logic b);
    logic [1:0] r;
    if (t == 2'd2) r = {b, 1'b0};
    else if (t == 2'd3) r = {c ^ b, 1'b0};
    else if (!c && b) r = 2'b10;
    else if (c && !b) r = 2'b01;
    else r = 2'b00;
    return r;
  endfunction

  task automatic run_vec(input vec_t v, input string nm);
    int n;
    @(negedge clk);
    ff_type = v.t;
    req_bit = v.b;
    stuck = v.stk;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      fail({nm, " ready"});
      req_valid = 1'b0;
      return;
    end
    m_type = v.t;
    sb.push_back(v.x);
    @(negedge clk);
    req_valid = 1'b0;
    ff_type = ~v.t;
    req_bit = ~v.b;
    chk({nm, " busy"}, busy, 1);
    n = 0;
    while (!tick && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (!tick) begin
      fail({nm, " tick"});
      return;
    end
    if (sb.size() > 0) chk({nm, " exc"}, exc, sb.pop_front());
    chk({nm, " exc_valid"}, exc_valid, 1);
    @(negedge clk);
    chk({nm, " mismatch"}, mismatch, v.mis);
    @(negedge clk);
    chk({nm, " err_cnt"}, err_cnt, v.err);
    chk({nm, " mis_end"}, mismatch, 0);
    chk({nm, " ev_end"}, exc_valid, 0);
    chk({nm, " rdy_end"}, req_ready, 1);
  endtask

  initial begin
    int acc;
    int done;
    int ticks;
    int n;
    tv[0]  = '{2'd1, 1'b1, 1'b0, 2'b10, 1'b0, 0};
    tv[1]  = '{2'd1, 1'b1, 1'b0, 2'b00, 1'b0, 0};
    tv[2]  = '{2'd1, 1'b0, 1'b0, 2'b01, 1'b0, 0};
    tv[3]  = '{2'd1, 1'b0, 1'b0, 2'b00, 1'b0, 0};
    tv[4]  = '{2'd0, 1'b1, 1'b0, 2'b10, 1'b0, 0};
    tv[5]  = '{2'd0, 1'b0, 1'b0, 2'b01, 1'b0, 0};
    tv[6]  = '{2'd0, 1'b1, 1'b0, 2'b10, 1'b0, 0};
    tv[7]  = '{2'd0, 1'b0, 1'b0, 2'b01, 1'b0, 0};
    tv[8]  = '{2'd3, 1'b1, 1'b0, 2'b10, 1'b0, 0};
    tv[9]  = '{2'd3, 1'b1, 1'b0, 2'b00, 1'b0, 0};
    tv[10] = '{2'd3, 1'b0, 1'b0, 2'b10, 1'b0, 0};
    tv[11] = '{2'd2, 1'b0, 1'b0, 2'b00, 1'b0, 0};
    tv[12] = '{2'd2, 1'b1, 1'b0, 2'b10, 1'b0, 0};
    tv[13] = '{2'd1, 1'b0, 1'b0, 2'b01, 1'b0, 0};
    tv[14] = '{2'd1, 1'b1, 1'b1, 2'b10, 1'b1, 1};
    tv[15] = '{2'd1, 1'b1, 1'b0, 2'b10, 1'b0, 1};
    tv[16] = '{2'd1, 1'b1, 1'b1, 2'b10, 1'b1, 1};
    tv[17] = '{2'd1, 1'b1, 1'b1, 2'b10, 1'b1, 2};
    tv[18] = '{2'd1, 1'b1, 1'b1, 2'b10, 1'b1, 3};
    tv[19] = '{2'd1, 1'b1, 1'b1, 2'b10, 1'b1, 3};
    tv[20] = '{2'd1, 1'b1, 1'b1, 2'b10, 1'b1, 3};

    repeat (3) @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst exc", exc, 0);
    chk("rst exc_valid", exc_valid, 0);
    chk("rst tick", tick, 0);
    chk("rst mismatch", mismatch, 0);
    chk("rst err_cnt", err_cnt, 0);
    chk("rst req_ready", req_ready, 0);
    rst = 1'b0;
    #1;
    chk("post-rst req_ready", req_ready, 1);

    for (int i = 0; i < 16; i++) run_vec(tv[i], $sformatf("v%0d", i));

    // request held high with a random target each cycle
    acc = 0;
    done = 0;
    ticks = 0;
    stuck = 1'b0;
    m_type = 2'd1;
    ff_type = 2'd1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (exc_valid && tick) begin
        if (sb.size() > 0) chk("hold exc", exc, sb.pop_front());
        else fail("hold scoreboard empty");
        done++;
      end
      if (busy) chk("hold ready while busy", req_ready, 0);
      if (tick && k < 28) ticks++;
      req_valid = (k < 28);
      req_bit = 1'($urandom_range(1));
      if (req_valid && req_ready) begin
        sb.push_back(exp_exc(2'd1, q_m, req_bit));
        acc++;
      end
    end
    chk("hold accepted==completed", acc, done);
    chk("hold scoreboard drained", sb.size(), 0);
    chk("hold one per tick", (acc <= ticks + 1), 1);
    chk("hold some accepted", (acc >= 5), 1);
    chk("hold err_cnt", err_cnt, 1);

    // reset in the middle of DRIVE
    @(negedge clk);
    ff_type = 2'd1;
    req_bit = ~q_m;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) fail("abort ready");
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort busy after rst", busy, 0);
    chk("abort exc", exc, 0);
    chk("abort exc_valid", exc_valid, 0);
    chk("abort err_cnt", err_cnt, 0);
    chk("abort tick", tick, 0);
    chk("abort mismatch", mismatch, 0);
    chk("abort req_ready in rst", req_ready, 0);
    rst = 1'b0;
    sb.delete();
    #1;
    chk("abort req_ready after rst", req_ready, 1);

    for (int i = 16; i < 21; i++) run_vec(tv[i], $sformatf("sat%0d", i - 16));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
